// File: rtl/posit_defines.sv
// posit_defines: shared widths, encodings and pipeline payload types for
// converting a 19-bit fixed-point quire into a posit<4,0>.
package posit_defines;
   localparam int QW = 19;
   localparam int FB = 4;
   localparam int PW = 4;
   localparam int ES = 0;
   localparam logic [PW-1:0] NAR    = 4'b1000;
   localparam logic [PW-1:0] MAXPOS = 4'b0111;
   localparam logic [PW-1:0] MINPOS = 4'b0001;
   localparam logic [PW-1:0] ZERO   = 4'b0000;

   typedef struct packed {
      logic          sow;
      logic          eow;
      logic          nar;
      logic [QW-1:0] data;
   } word_t;

   typedef struct packed {
      logic          sow;
      logic          eow;
      logic          nar;
      logic          sign;
      logic [QW-1:0] mag;
   } abs_t;

   typedef struct packed {
      logic              sow;
      logic              eow;
      logic              nar;
      logic              sign;
      logic              zero;
      logic signed [5:0] scale;
      logic [1:0]        frac;
      logic              sticky;
   } norm_t;
endpackage

// File: rtl/lzc_19.sv
// lzc_19: leading-zero count of a 19-bit word plus an all-zero flag.
module lzc_19 (
   input  logic [18:0] a,
   output logic [4:0]  cnt,
   output logic        zero
);
   always_comb begin
      cnt = '0;
      for (int i = 0; i < 19; i++) if (a[i]) cnt = 5'(18 - i);
   end

   assign zero = ~|a;
endmodule

// File: rtl/quire_to_posit_4_0.sv
// quire_to_posit_4_0: 3-stage rts/rtr pipeline (abs, normalize, round+encode)
// turning a signed 19-bit quire with 4 fraction bits into a posit<4,0>.
module quire_to_posit_4_0
   import posit_defines::*;
#(
   parameter bit ONLY_EOW = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rts_i,
   output logic          rtr_o,
   input  logic          sow_i,
   input  logic          eow_i,
   input  logic [QW-1:0] data_i,
   input  logic          NaR_i,
   input  logic          rtr_i,
   output logic          rts_o,
   output logic          sow_o,
   output logic          eow_o,
   output logic [PW-1:0] posit_o,
   output logic          NaR_o,
   output logic          zero_o,
   output logic          sign_o
);
   logic              process_en, en1, en2, in_xfer, src_v;
   logic              v1, v2, skid_v;
   word_t             in_word, skid, src;
   abs_t              s1, s1_n;
   norm_t             s2, s2_n;
   logic [4:0]        lz;
   logic              lz_zero;
   logic [QW-1:0]     norm;
   logic signed [5:0] k;
   logic              outer, guard, sticky;
   logic [2:0]        body, pos;
   logic [PW-1:0]     posit_n;

   // a stage may also load when it is empty, so bubbles collapse under stall
   assign process_en = rtr_i | ~rts_o;
   assign en2        = process_en | ~v2;
   assign en1        = en2 | ~v1;
   assign in_xfer    = rts_i & rtr_o;
   assign in_word    = '{sow: sow_i, eow: eow_i, nar: NaR_i, data: data_i};
   assign src        = skid_v ? skid : in_word;
   assign src_v      = (skid_v | in_xfer) & (src.eow | ~ONLY_EOW);

   always_comb begin
      s1_n = '{sow: src.sow, eow: src.eow, nar: src.nar, sign: src.data[QW-1],
               mag: src.data[QW-1] ? -src.data : src.data};
   end

   lzc_19 u_lzc (.a(s1.mag), .cnt(lz), .zero(lz_zero));

   always_comb begin
      norm = s1.mag << lz;
      s2_n = '{sow: s1.sow, eow: s1.eow, nar: s1.nar, sign: s1.sign, zero: lz_zero,
               scale: 6'(QW - 1 - FB) - 6'(lz), frac: norm[QW-2 -: 2],
               sticky: |norm[QW-4:0]};
   end

   // regime k is 110 / 10f / 01f / 001 for k = 1..-2; outer regimes leave no fraction bit
   always_comb begin
      k       = $signed(s2.scale) >>> ES;
      outer   = (k == 6'sd1) || (k == -6'sd2);
      body    = k == 6'sd1 ? 3'b110 : k == 6'sd0 ? {2'b10, s2.frac[1]} :
                k == -6'sd1 ? {2'b01, s2.frac[1]} : 3'b001;
      guard   = outer ? s2.frac[1] : s2.frac[0];
      sticky  = outer ? (s2.frac[0] | s2.sticky) : s2.sticky;
      pos     = k > 6'sd1 ? MAXPOS[2:0] : k < -6'sd2 ? MINPOS[2:0] :
                body + {2'b00, guard & (sticky | body[0])};
      posit_n = s2.nar ? NAR : s2.zero ? ZERO : s2.sign ? -{1'b0, pos} : {1'b0, pos};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rtr_o   <= 1'b0;
         skid_v  <= 1'b0;
         skid    <= '0;
         v1      <= 1'b0;
         s1      <= '0;
         v2      <= 1'b0;
         s2      <= '0;
         rts_o   <= 1'b0;
         sow_o   <= 1'b0;
         eow_o   <= 1'b0;
         posit_o <= ZERO;
         NaR_o   <= 1'b0;
         zero_o  <= 1'b1;
         sign_o  <= 1'b0;
      end else begin
         rtr_o <= process_en;
         if (in_xfer) skid <= in_word;
         if (en1) begin
            skid_v <= skid_v & in_xfer;
            v1     <= src_v;
            s1     <= s1_n;
         end else if (in_xfer) begin
            skid_v <= 1'b1;
         end
         if (en2) begin
            v2 <= v1;
            s2 <= s2_n;
         end
         if (process_en) begin
            rts_o   <= v2;
            sow_o   <= s2.sow;
            eow_o   <= s2.eow;
            posit_o <= posit_n;
            NaR_o   <= s2.nar;
            zero_o  <= s2.zero & ~s2.nar;
            sign_o  <= posit_n[PW-1];
         end
      end
   end
endmodule

// File: tb/tb_quire_to_posit_4_0.sv
// tb_quire_to_posit_4_0: directed and randomized checks of the quire-to-posit
// pipeline against a value-level posit<4,0> rounding model.
module tb_quire_to_posit_4_0;
   localparam bit ONLY = 1'b1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rts_i = 1'b0, rtr_i = 1'b0, sow_i = 1'b0, eow_i = 1'b0, NaR_i = 1'b0;
   logic [18:0] data_i = '0;
   logic        rtr_o, rts_o, sow_o, eow_o, NaR_o, zero_o, sign_o;
   logic [3:0]  posit_o;
   logic        rts0 = 1'b0;
   logic        rtr_o0, rts_o0, sow0, eow0, nar0, zero0, sign0;
   logic [3:0]  posit0;
   logic [8:0]  outv;

   int          n_tests = 0, n_fail = 0, n_out = 0, n0 = 0;
   logic [8:0]  q[$];
   logic        stalled = 1'b0, acc = 1'b0;
   logic [8:0]  held = '0;

   logic [18:0] d_data [11] = '{19'd16, 19'd24, 19'd20, 19'd48, 19'd256, 19'd1, 19'd2,
                                19'h40000, 19'h7FFF0, 19'd16, 19'd0};
   logic        d_nar  [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
   logic [3:0]  d_exp  [11] = '{4'h4, 4'h5, 4'h4, 4'h6, 4'h7, 4'h1, 4'h1,
                                4'h9, 4'hC, 4'h8, 4'h0};

   always #5 clk = ~clk;

   quire_to_posit_4_0 #(.ONLY_EOW(ONLY)) dut (
      .clk(clk), .rst_n(rst_n), .rts_i(rts_i), .rtr_o(rtr_o), .sow_i(sow_i), .eow_i(eow_i),
      .data_i(data_i), .NaR_i(NaR_i), .rtr_i(rtr_i), .rts_o(rts_o), .sow_o(sow_o),
      .eow_o(eow_o), .posit_o(posit_o), .NaR_o(NaR_o), .zero_o(zero_o), .sign_o(sign_o));

   quire_to_posit_4_0 #(.ONLY_EOW(1'b0)) u0 (
      .clk(clk), .rst_n(rst_n), .rts_i(rts0), .rtr_o(rtr_o0), .sow_i(sow_i), .eow_i(eow_i),
      .data_i(data_i), .NaR_i(NaR_i), .rtr_i(1'b1), .rts_o(rts_o0), .sow_o(sow0),
      .eow_o(eow0), .posit_o(posit0), .NaR_o(nar0), .zero_o(zero0), .sign_o(sign0));

   assign outv = {posit_o, NaR_o, zero_o, sign_o, sow_o, eow_o};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // posit<4,0> positive values in 1/16 units, indexed by pattern
   function automatic logic [8:0] model(input logic [21:0] w);
      int tbl [8];
      int sd, m, bd, dd;
      logic [3:0] p;
      tbl = '{0, 4, 8, 12, 16, 24, 32, 64};
      sd = int'($signed(w[18:0]));
      m = sd < 0 ? -sd : sd;
      if (w[19]) return {4'h8, 1'b1, 1'b0, 1'b1, w[21], w[20]};
      if (m == 0) return {4'h0, 1'b0, 1'b1, 1'b0, w[21], w[20]};
      p = 4'd1;
      bd = 1 << 30;
      if (m >= 64) p = 4'd7;
      else if (m >= 4)
         for (int j = 1; j < 8; j++) begin
            dd = m > tbl[j] ? m - tbl[j] : tbl[j] - m;
            if (dd < bd || (dd == bd && j % 2 == 0)) begin
               bd = dd;
               p = 4'(j);
            end
         end
      if (sd < 0) p = -p;
      return {p, 1'b0, 1'b0, p[3], w[21], w[20]};
   endfunction

   function automatic logic [21:0] rand_word();
      logic [18:0] d;
      d = $urandom_range(0, 3) == 0 ? 19'($urandom) : 19'(int'($urandom_range(0, 255)) - 128);
      return {1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0, d};
   endfunction

   task automatic cyc(input bit rv, input logic [21:0] w, input bit rr, input bit r0,
                      input logic [8:0] ex);
      @(negedge clk);
      if (stalled) check("hold", 32'({rts_o, outv}), 32'({1'b1, held}));
      rts_i = rv;
      {sow_i, eow_i, NaR_i, data_i} = w;
      rtr_i = rr;
      rts0 = r0;
      if (rts_o0) n0++;
      acc = rv && rtr_o;
      if (acc && (w[20] || !ONLY)) q.push_back(ex);
      if (rts_o && rtr_i) begin
         n_out++;
         if (q.size() == 0) check("spurious_rts", 32'(rts_o), 32'(0));
         else check("out", 32'(outv), 32'(q.pop_front()));
      end
      stalled = rts_o && !rtr_i;
      held = outv;
   endtask

   initial begin
      logic [21:0] w;
      int lat, sent, cycles, nb, n0b;
      repeat (3) @(negedge clk);
      check("reset_state", 32'({rts_o, rtr_o, outv}), 32'(11'b00_0000_0_1_0_0_0));
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rtr_before_edge", 32'(rtr_o), 32'(0));
      cyc(0, '0, 1, 0, '0);
      check("rtr_after_reset", 32'(rtr_o), 32'(1));

      w = {2'b11, 1'b0, 19'd24};
      cyc(1, w, 1, 0, model(w));
      lat = 0;
      while (lat < 10) begin
         cyc(0, '0, 1, 0, '0);
         lat++;
         if (rts_o) break;
      end
      check("latency", 32'(lat), 32'(3));
      repeat (2) cyc(0, '0, 1, 0, '0);

      for (int i = 0; i < 11; i++) begin
         w = {2'b11, d_nar[i], d_data[i]};
         cyc(1, w, 1, 0, {d_exp[i], d_nar[i], 1'(i == 10), d_exp[i][3], 2'b11});
      end
      repeat (6) cyc(0, '0, 1, 0, '0);
      check("directed_drain", 32'(q.size()), 32'(0));

      nb = n_out;
      n0b = n0;
      for (int i = 0; i < 8; i++) begin
         w = rand_word();
         w[20] = (i == 3 || i == 7);
         cyc(1, w, 1, 1, model(w));
      end
      repeat (8) cyc(0, '0, 1, 0, '0);
      check("eow_only_count", 32'(n_out - nb), 32'(2));
      check("all_words_count", 32'(n0 - n0b), 32'(8));

      sent = 0;
      cycles = 0;
      while (sent < 1000 && cycles < 20000) begin
         w = rand_word();
         cyc($urandom_range(0, 9) < 7, w, $urandom_range(0, 9) < 6, 0, model(w));
         if (acc) sent++;
         cycles++;
      end
      check("random_sent", 32'(sent), 32'(1000));
      for (int i = 0; i < 50 && q.size() > 0; i++) cyc(0, '0, 1, 0, '0);
      check("random_drain", 32'(q.size()), 32'(0));
      repeat (4) cyc(0, '0, 1, 0, '0);

      for (int i = 0; i < 3; i++) begin
         w = {2'b11, 1'b0, 19'(16 * (i + 1))};
         cyc(1, w, 1, 0, model(w));
      end
      cyc(0, '0, 0, 0, '0);
      check("inflight_before_reset", 32'(rts_o), 32'(1));
      #2 rst_n = 1'b0;
      #1 check("async_reset", 32'({rts_o, rtr_o, outv}), 32'(11'b00_0000_0_1_0_0_0));
      q.delete();
      stalled = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 check("rtr_release", 32'(rtr_o), 32'(0));
      cyc(0, '0, 1, 0, '0);
      check("rtr_after_release", 32'(rtr_o), 32'(1));
      nb = n_out;
      repeat (10) cyc(0, '0, 1, 0, '0);
      check("no_output_after_reset", 32'(n_out - nb), 32'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
